// File: rtl/tdm_demux32.sv
// TDM demultiplexer: collects 32 serial slots into a frame and publishes it on W.
// Optional macro TDM_DEMUX_PARITY_EN adds a 33rd even-parity slot per frame.
module tdm_demux32 (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        d,
   input  logic        en,
   input  logic        sync,
   output logic [0:31] W,
   output logic        valid,
   output logic        busy,
   output logic        ferr,
   output logic        perr
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] LastSlot = 6'd32;
`else
   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] LastSlot = 5'd31;
`endif

   typedef enum logic [0:0] {StIdle, StRecv} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [0:31]   cap_q;
   logic [0:31]   w_q;
   logic          valid_q;
   logic          ferr_q;
   logic          perr_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cap_q   <= '0;
         w_q     <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (en && sync) begin
                  cap_q    <= '0;
                  cap_q[0] <= d;
                  cnt_q    <= CW'(1);
                  state_q  <= StRecv;
               end
            end
            StRecv: begin
               if (en) begin
                  if (sync) begin
                     // Early sync wins even on the final slot: restart, flag the abort.
                     cap_q    <= '0;
                     cap_q[0] <= d;
                     cnt_q    <= CW'(1);
                     ferr_q   <= 1'b1;
                  end else if (cnt_q == LastSlot) begin
`ifdef TDM_DEMUX_PARITY_EN
                     if (^{cap_q, d}) begin
                        perr_q <= 1'b1;
                     end else begin
                        w_q     <= cap_q;
                        valid_q <= 1'b1;
                     end
`else
                     w_q     <= {cap_q[0:30], d};
                     valid_q <= 1'b1;
`endif
                     cnt_q   <= '0;
                     state_q <= StIdle;
                  end else begin
                     cap_q[cnt_q[4:0]] <= d;
                     cnt_q             <= cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign W     = w_q;
   assign valid = valid_q;
   assign busy  = (state_q == StRecv);
   assign ferr  = ferr_q;
   assign perr  = perr_q;

endmodule

// File: tb/tb_tdm_demux32.sv
// Directed self-checking bench for tdm_demux32 (default and TDM_DEMUX_PARITY_EN builds).
module tb_tdm_demux32;

`ifdef TDM_DEMUX_PARITY_EN
   localparam int NSLOT = 33;
`else
   localparam int NSLOT = 32;
`endif

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        d = 1'b0;
   logic        en = 1'b0;
   logic        sync = 1'b0;
   logic [0:31] W;
   logic        valid;
   logic        busy;
   logic        ferr;
   logic        perr;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_w = 32'h0;

   tdm_demux32 dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .d     (d),
      .en    (en),
      .sync  (sync),
      .W     (W),
      .valid (valid),
      .busy  (busy),
      .ferr  (ferr),
      .perr  (perr)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive on the falling edge, return 1ns after the sampling rising edge.
   task automatic step(input logic bd, input logic be, input logic bs);
      @(negedge Clock);
      d = bd;
      en = be;
      sync = bs;
      @(posedge Clock);
      #1;
   endtask

   task automatic flags(input string tag, input logic [3:0] expv);
      chk(tag, {28'h0, busy, valid, ferr, perr}, {28'h0, expv});
   endtask

   // Sends slots start..stop of frame v; stop = NSLOT-1 completes the frame.
   task automatic frame(input logic [31:0] v, input int start, input int stop,
                        input int gap_after, input int gap_len, input bit bad_par);
      logic b;
      for (int i = start; i <= stop; i++) begin
         b = (i < 32) ? v[31-i] : ((^v) ^ bad_par);
         step(b, 1'b1, i == 0);
         if (i < NSLOT - 1) begin
            flags("slot_flags", 4'b1000);
            chk("slot_w_hold", W, exp_w);
         end
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               step(1'($urandom_range(1)), 1'b0, 1'b1);
               flags("gap_flags", 4'b1000);
            end
         end
      end
      if (stop == NSLOT - 1) begin
         if (bad_par) begin
            flags("final_perr", 4'b0001);
         end else begin
            flags("final_valid", 4'b0100);
            exp_w = v;
         end
         chk("final_w", W, exp_w);
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge Clock);
      #1;
      flags("reset_flags", 4'b0000);
      chk("reset_w", W, 32'h0);
      @(negedge Clock);
      Resetn = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      flags("idle_ignores_nosync", 4'b0000);

      // Basic frame
      frame(32'hA5C3_0F81, 0, NSLOT - 1, -1, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      flags("valid_one_cycle", 4'b0000);
      chk("w_hold_idle", W, 32'hA5C3_0F81);

      // Same frame with a 3-cycle en gap after slot 10
      frame(32'hA5C3_0F81, 0, NSLOT - 1, 10, 3, 1'b0);

      // Early sync at slot 17 then a full frame
      frame(32'h5555_AAAA, 0, 16, -1, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      flags("ferr_pulse", 4'b1010);
      frame(32'hFFFF_0000, 1, NSLOT - 1, -1, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      flags("after_ferr_frame", 4'b0000);

      // Sync on the final-slot cycle restarts instead of completing
      frame(32'h0F0F_F0F0, 0, NSLOT - 2, -1, 0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      flags("final_sync_ferr", 4'b1010);
      chk("final_sync_w", W, exp_w);
      frame(32'h1234_5678, 1, NSLOT - 1, -1, 0, 1'b0);
      chk("restart_low_slot0", W, 32'h1234_5678);

      // Back-to-back frames
      frame(32'h1234_5678, 0, NSLOT - 1, -1, 0, 1'b0);
      frame(32'h8765_4321, 0, NSLOT - 1, -1, 0, 1'b0);

      // Reset mid-frame at slot 20
      frame(32'hDEAD_BEEF, 0, 19, -1, 0, 1'b0);
      @(negedge Clock);
      Resetn = 1'b0;
      #1;
      flags("async_reset_flags", 4'b0000);
      chk("async_reset_w", W, 32'h0);
      exp_w = 32'h0;
      step(1'b1, 1'b1, 1'b0);
      @(negedge Clock);
      Resetn = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      flags("post_reset_idle", 4'b0000);
      chk("post_reset_w", W, 32'h0);
      frame(32'h0F0F_1234, 0, NSLOT - 1, -1, 0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
      frame(32'h0000_0001, 0, NSLOT - 1, -1, 0, 1'b0);
      frame(32'h8000_0003, 0, NSLOT - 1, -1, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      flags("after_perr", 4'b0000);
      chk("after_perr_w", W, 32'h0000_0001);
`else
      chk("perr_tied", {31'h0, perr}, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
